// File: rtl/sbox_ti_pkg.sv
// Shared definitions for the 4-share threshold-implemented 4-bit S-box datapath.
package sbox_ti_pkg;

  localparam int unsigned NSHARE  = 4;
  localparam int unsigned NBIT    = 4;
  localparam int unsigned SHARE_W = NSHARE * NBIT;
  localparam int unsigned RND_W   = (NSHARE - 1) * NBIT;

  typedef logic [NBIT-1:0]    nibble_t;
  typedef logic [SHARE_W-1:0] shares_t;
  typedef logic [RND_W-1:0]   masks_t;

  // Recombine all shares into the plain nibble; callers must feed registers only.
  function automatic nibble_t share_xor(input shares_t shares);
    nibble_t acc;
    acc = '0;
    for (int unsigned k = 0; k < NSHARE; k++) begin
      acc = acc ^ shares[k*NBIT +: NBIT];
    end
    return acc;
  endfunction

endpackage

// File: rtl/ti_ring_refresh.sv
// Combinational ring refresh: mask k is folded into shares k and k+1, so every
// mask appears exactly twice and the XOR of all shares is preserved.
module ti_ring_refresh #(
  parameter int unsigned NSHARE = 4,
  parameter int unsigned NBIT   = 4
) (
  input  logic [NSHARE*NBIT-1:0]     shares,
  input  logic [(NSHARE-1)*NBIT-1:0] masks,
  output logic [NSHARE*NBIT-1:0]     refreshed
);

  // Each share sees at most its two neighbouring masks; no two shares are mixed.
  always_comb begin
    refreshed = shares;
    for (int unsigned k = 0; k < NSHARE - 1; k++) begin
      refreshed[k*NBIT +: NBIT]     = refreshed[k*NBIT +: NBIT]     ^ masks[k*NBIT +: NBIT];
      refreshed[(k+1)*NBIT +: NBIT] = refreshed[(k+1)*NBIT +: NBIT] ^ masks[k*NBIT +: NBIT];
    end
  end

endmodule

// File: rtl/sbox_ti_unmask.sv
// Receiving end of the TI S-box: capture shares (A), ring-refresh them (B),
// recombine into the plain nibble (C). Shares only meet after stage B's registers.
module sbox_ti_unmask #(
  parameter int unsigned NSHARE     = 4,
  parameter int unsigned NBIT       = 4,
  parameter int unsigned CNT_W      = 16,
  parameter bit          REFRESH_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSHARE*NBIT-1:0]   in_shares,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [(NSHARE-1)*NBIT-1:0] rnd,
  output logic                     rnd_ack,
  output logic [NBIT-1:0]          out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_count
);

  import sbox_ti_pkg::*;

  localparam int unsigned SH_W = NSHARE * NBIT;

  logic            rdy_q;
  logic [SH_W-1:0] a_sh;
  logic            va;
  logic [SH_W-1:0] b_sh;
  logic            vb;
  logic [SH_W-1:0] ref_sh;
  logic [SH_W-1:0] b_next;
  logic            ready_a;
  logic            ready_b;
  logic            ready_c;

  assign ready_c  = !out_valid || out_ready;
  assign ready_b  = !vb || ready_c;
  assign ready_a  = !va || ready_b;
  assign in_ready = rdy_q && ready_a;
  assign rnd_ack  = va && ready_b;

  ti_ring_refresh #(
    .NSHARE (NSHARE),
    .NBIT   (NBIT)
  ) u_refresh (
    .shares    (a_sh),
    .masks     (rnd),
    .refreshed (ref_sh)
  );

  assign b_next = REFRESH_EN ? ref_sh : a_sh;

  // Hold in_ready low until the first clock after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= 1'b0;
    else     rdy_q <= 1'b1;
  end

  // Stage A: capture incoming shares; accept and drain may coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      va   <= 1'b0;
    end else if (in_valid && in_ready) begin
      a_sh <= in_shares;
      va   <= 1'b1;
    end else if (ready_b) begin
      va   <= 1'b0;
    end
  end

  // Stage B: register refreshed shares; rnd is consumed on this transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_sh <= '0;
      vb   <= 1'b0;
    end else if (va && ready_b) begin
      b_sh <= b_next;
      vb   <= 1'b1;
    end else if (ready_c) begin
      vb   <= 1'b0;
    end
  end

  // Stage C: recombine from stage-B registers; data holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (vb && ready_c) begin
      out_data  <= share_xor(b_sh);
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Delivered-nibble counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        out_count <= '0;
    else if (out_valid && out_ready) out_count <= out_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_sbox_ti_unmask.sv
// Scoreboard bench for sbox_ti_unmask (counter width reduced to 4 to exercise wrap).
module tb_sbox_ti_unmask;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   in_shares = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [11:0]   rnd = '0;
  logic          rnd_ack;
  logic [3:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CW-1:0] out_count;

  always #5 clk = ~clk;

  sbox_ti_unmask #(
    .NSHARE     (4),
    .NBIT       (4),
    .CNT_W      (CW),
    .REFRESH_EN (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_shares (in_shares),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rnd       (rnd),
    .rnd_ack   (rnd_ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  typedef struct { logic [3:0] v; int unsigned cyc; bit lat; } exp_t;
  typedef struct { logic [15:0] sh; int unsigned cyc; bit lat; } ain_t;

  exp_t exp_q[$];
  ain_t a_q[$];

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned n_acc = 0;
  int unsigned n_ack = 0;
  logic [CW-1:0] exp_cnt = '0;
  bit lat_mode = 1'b0;
  bit rnd_rand = 1'b0;
  bit stream_done = 1'b0;
  bit b_pend = 1'b0;
  logic [15:0] b_exp;
  bit hold_pend = 1'b0;
  logic [3:0] hold_data;
  exp_t e;
  ain_t a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Ring refresh written directly from the per-share equations.
  function automatic logic [15:0] ring(input logic [15:0] s, input logic [11:0] r);
    logic [3:0] s0, s1, s2, s3, r0, r1, r2;
    {s3, s2, s1, s0} = s;
    {r2, r1, r0} = r;
    return {s3 ^ r2, s2 ^ r1 ^ r2, s1 ^ r0 ^ r1, s0 ^ r0};
  endfunction

  // Random 4-way XOR sharing of a plain nibble.
  function automatic logic [15:0] split(input logic [3:0] v);
    logic [3:0] s0, s1, s2;
    s0 = 4'($urandom);
    s1 = 4'($urandom);
    s2 = 4'($urandom);
    return {v ^ s0 ^ s1 ^ s2, s2, s1, s0};
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rnd_rand) rnd = 12'($urandom);
  end

  // Monitor: compares everything the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (rst) begin
      b_pend = 1'b0;
      hold_pend = 1'b0;
    end else begin
      check("out_count", 32'(out_count), 32'(exp_cnt));
      if (b_pend) begin
        check("stage_b_shares", 32'(dut.b_sh), 32'(b_exp));
        b_pend = 1'b0;
      end
      if (hold_pend) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(hold_data));
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (rnd_ack) begin
        n_ack++;
        if (a_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rnd_ack: got 1, expected 0 (nothing captured)");
        end else begin
          a = a_q.pop_front();
          if (a.lat) check("rnd_ack_cycle", cyc, a.cyc + 1);
          b_exp = ring(a.sh, rnd);
          b_pend = 1'b1;
        end
      end
      if (out_valid && out_ready) begin
        exp_cnt = exp_cnt + 1'b1;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got 0x%0h, expected no output", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.v));
          if (e.lat) check("latency", cyc, e.cyc + 3);
        end
      end
    end
  end

  task automatic send(input logic [3:0] v, input logic [15:0] sh, input bit must_ready);
    int unsigned w = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_shares = sh;
    while (!done) begin
      @(negedge clk);
      if (must_ready) check("in_ready_full_rate", 32'(in_ready), 32'd1);
      if (in_ready) begin
        exp_q.push_back('{v, cyc, lat_mode});
        a_q.push_back('{sh, cyc, lat_mode});
        n_acc++;
        done = 1'b1;
      end else if (++w > 200) begin
        tests++; fails++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending outputs, expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    int unsigned g;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_rnd_ack", 32'(rnd_ack), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("in_ready_after_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Single nibble with fixed mask
    lat_mode = 1'b1;
    rnd = 12'hA5C;
    send(4'h9, 16'h6953, 1'b0);
    drain();
    check("single_count", 32'(out_count), 32'd1);
    check("single_rnd_ack", n_ack, 32'd1);

    // Refresh invariance over masks
    for (int i = 0; i < 66; i++) begin
      rnd = (i == 0) ? 12'h000 : (i == 1) ? 12'hFFF : 12'($urandom);
      send(4'h9, 16'h6953, 1'b0);
      drain();
    end

    // Full-rate stream 0..F
    rnd_rand = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      send(v, split(v), 1'b1);
    end
    drain();

    // Backpressure: 6 stalled cycles mid-stream
    lat_mode = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          v = 4'($urandom);
          send(v, split(v), 1'b0);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_queued", 32'(exp_q.size()), 32'd3);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("rnd_ack_total_bp", n_ack, n_acc);

    // Random traffic with random backpressure
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          g = $urandom_range(0, 2);
          if (g != 0) begin
            repeat (g) @(posedge clk);
            #1;
          end
          v = 4'($urandom);
          send(v, split(v), 1'b0);
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("rnd_ack_total_rand", n_ack, n_acc);

    // Async reset with 3 nibbles in flight
    for (int i = 0; i < 3; i++) begin
      v = 4'($urandom);
      send(v, split(v), 1'b0);
    end
    #2;
    rst = 1'b1;
    exp_q.delete();
    a_q.delete();
    exp_cnt = '0;
    n_acc = 0;
    n_ack = 0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_out_count", 32'(out_count), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    lat_mode = 1'b1;
    v = 4'($urandom);
    send(v, split(v), 1'b0);
    drain();
    check("post_reset_count", 32'(out_count), 32'd1);
    check("rnd_ack_total_reset", n_ack, n_acc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
